// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and datapath mux selects.
// Also holds a helper that maps I-type opcodes to ALU operations.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        R_EXEC    = 4'd3,
        R_WB      = 4'd4,
        I_EXEC    = 4'd5,
        I_WB      = 4'd6,
        MEM_ADDR  = 4'd7,
        MEM_READ  = 4'd8,
        MEM_WB    = 4'd9,
        MEM_WRITE = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        JAL       = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_XOR   = 3'b101;
    localparam logic [2:0] ALUOP_SLT   = 3'b110;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    function automatic logic [2:0] immAluOp(input logic [5:0] op);
        case (op)
            OP_SLTI: immAluOp = ALUOP_SLT;
            OP_ANDI: immAluOp = ALUOP_AND;
            OP_ORI:  immAluOp = ALUOP_OR;
            OP_XORI: immAluOp = ALUOP_XOR;
            default: immAluOp = ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle: instruction fields and memory handshake in, control enables out.
// master = controller side, slave = datapath side.
interface multicycle_control_if #(parameter int CNT_W = 32);
    logic [5:0]       opCode;
    logic             zero;
    logic             memReady;
    logic             pcEn;
    logic             iorD;
    logic             memRead;
    logic             memWrite;
    logic             irWrite;
    logic [1:0]       regDst;
    logic [1:0]       memtoReg;
    logic             regWrite;
    logic             aluSrcA;
    logic [1:0]       aluSrcB;
    logic [2:0]       aluOp;
    logic [1:0]       pcSource;
    logic             instrDone;
    logic             illegalOp;
    logic             busErr;
    logic [CNT_W-1:0] instrCount;

    modport master (
        input  opCode, zero, memReady,
        output pcEn, iorD, memRead, memWrite, irWrite, regDst, memtoReg, regWrite,
               aluSrcA, aluSrcB, aluOp, pcSource, instrDone, illegalOp, busErr, instrCount
    );

    modport slave (
        output opCode, zero, memReady,
        input  pcEn, iorD, memRead, memWrite, irWrite, regDst, memtoReg, regWrite,
               aluSrcA, aluSrcB, aluOp, pcSource, instrDone, illegalOp, busErr, instrCount
    );
endinterface

// File: rtl/mc_mem_watchdog.sv
// Memory wait watchdog: counts consecutive wait cycles, flags expiry combinationally on the last allowed one.
// Latency: expiry seen in the same cycle as the final wait; memReady in that cycle suppresses it.
module mc_mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    input  logic memReady,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] waitCnt;

    assign expired = waiting && !memReady && (waitCnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            waitCnt <= '0;
        end else if (clear || memReady || expired) begin
            waitCnt <= '0;
        end else if (waiting) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller FSM (MC_CTRL_JAL_EN adds the JAL state); 3-5 cycles per instruction.
// Stalls in FETCH/MEM_READ/MEM_WRITE until memReady; watchdog expiry aborts to IDLE with busErr.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master ctl
);
    state_t           state, nextState;
    logic [CNT_W-1:0] instrCnt;
    logic             expired, waiting, enterWait;

    logic       pcEnC, iorDC, memReadC, memWriteC, irWriteC, regWriteC, aluSrcAC;
    logic       doneC, illegalC, busErrC;
    logic [1:0] regDstC, memtoRegC, aluSrcBC, pcSourceC;
    logic [2:0] aluOpC;

    assign waiting   = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
    assign enterWait = (nextState != state) &&
                       ((nextState == FETCH) || (nextState == MEM_READ) || (nextState == MEM_WRITE));

    mc_mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (enterWait),
        .waiting  (waiting),
        .memReady (ctl.memReady),
        .expired  (expired)
    );

    always_comb begin
        nextState = state;
        pcEnC     = 1'b0;
        iorDC     = 1'b0;
        memReadC  = 1'b0;
        memWriteC = 1'b0;
        irWriteC  = 1'b0;
        regDstC   = REGDST_RT;
        memtoRegC = M2R_ALUOUT;
        regWriteC = 1'b0;
        aluSrcAC  = 1'b0;
        aluSrcBC  = SRCB_REGB;
        aluOpC    = ALUOP_ADD;
        pcSourceC = PCSRC_ALU;
        doneC     = 1'b0;
        illegalC  = 1'b0;
        busErrC   = 1'b0;
        case (state)
            IDLE: nextState = FETCH;
            FETCH: begin
                memReadC = 1'b1;
                aluSrcBC = SRCB_FOUR;
                if (ctl.memReady) begin
                    irWriteC  = 1'b1;
                    pcEnC     = 1'b1;
                    nextState = DECODE;
                end else if (expired) begin
                    busErrC   = 1'b1;
                    nextState = IDLE;
                end
            end
            DECODE: begin
                // Branch target computed here so BRANCH can compare and select in one cycle.
                aluSrcBC = SRCB_IMMSH;
                case (ctl.opCode)
                    OP_RTYPE:                                  nextState = R_EXEC;
                    OP_LW, OP_SW:                              nextState = MEM_ADDR;
                    OP_BEQ:                                    nextState = BRANCH;
                    OP_J:                                      nextState = JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: nextState = I_EXEC;
`ifdef MC_CTRL_JAL_EN
                    OP_JAL:                                    nextState = JAL;
`endif
                    default: begin
                        illegalC  = 1'b1;
                        nextState = FETCH;
                    end
                endcase
            end
            R_EXEC: begin
                aluSrcAC  = 1'b1;
                aluOpC    = ALUOP_FUNCT;
                nextState = R_WB;
            end
            R_WB: begin
                regDstC   = REGDST_RD;
                regWriteC = 1'b1;
                doneC     = 1'b1;
                nextState = FETCH;
            end
            I_EXEC: begin
                aluSrcAC  = 1'b1;
                aluSrcBC  = SRCB_IMM;
                aluOpC    = immAluOp(ctl.opCode);
                nextState = I_WB;
            end
            I_WB: begin
                regWriteC = 1'b1;
                doneC     = 1'b1;
                nextState = FETCH;
            end
            MEM_ADDR: begin
                aluSrcAC  = 1'b1;
                aluSrcBC  = SRCB_IMM;
                nextState = (ctl.opCode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                memReadC = 1'b1;
                iorDC    = 1'b1;
                if (ctl.memReady) begin
                    nextState = MEM_WB;
                end else if (expired) begin
                    busErrC   = 1'b1;
                    nextState = IDLE;
                end
            end
            MEM_WB: begin
                memtoRegC = M2R_MDR;
                regWriteC = 1'b1;
                doneC     = 1'b1;
                nextState = FETCH;
            end
            MEM_WRITE: begin
                memWriteC = 1'b1;
                iorDC     = 1'b1;
                if (ctl.memReady) begin
                    doneC     = 1'b1;
                    nextState = FETCH;
                end else if (expired) begin
                    busErrC   = 1'b1;
                    nextState = IDLE;
                end
            end
            BRANCH: begin
                aluSrcAC  = 1'b1;
                aluOpC    = ALUOP_SUB;
                pcSourceC = PCSRC_ALUOUT;
                pcEnC     = ctl.zero;
                doneC     = 1'b1;
                nextState = FETCH;
            end
            JUMP: begin
                pcEnC     = 1'b1;
                pcSourceC = PCSRC_JUMP;
                doneC     = 1'b1;
                nextState = FETCH;
            end
`ifdef MC_CTRL_JAL_EN
            JAL: begin
                // PC was already advanced in FETCH, so it is the return address.
                pcEnC     = 1'b1;
                pcSourceC = PCSRC_JUMP;
                regWriteC = 1'b1;
                regDstC   = REGDST_RA;
                memtoRegC = M2R_PC;
                doneC     = 1'b1;
                nextState = FETCH;
            end
`endif
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            instrCnt <= '0;
        end else begin
            state <= nextState;
            if (doneC) begin
                instrCnt <= instrCnt + 1'b1;
            end
        end
    end

    assign ctl.pcEn       = rst_n & pcEnC;
    assign ctl.iorD       = rst_n & iorDC;
    assign ctl.memRead    = rst_n & memReadC;
    assign ctl.memWrite   = rst_n & memWriteC;
    assign ctl.irWrite    = rst_n & irWriteC;
    assign ctl.regDst     = rst_n ? regDstC   : 2'b00;
    assign ctl.memtoReg   = rst_n ? memtoRegC : 2'b00;
    assign ctl.regWrite   = rst_n & regWriteC;
    assign ctl.aluSrcA    = rst_n & aluSrcAC;
    assign ctl.aluSrcB    = rst_n ? aluSrcBC  : 2'b00;
    assign ctl.aluOp      = rst_n ? aluOpC    : 3'b000;
    assign ctl.pcSource   = rst_n ? pcSourceC : 2'b00;
    assign ctl.instrDone  = rst_n & doneC;
    assign ctl.illegalOp  = rst_n & illegalC;
    assign ctl.busErr     = rst_n & busErrC;
    assign ctl.instrCount = rst_n ? instrCnt : '0;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected control words queued at drive time, checked at negedge.
module tb_multicycle_control;
    localparam int TO = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic       pcEn, iorD, memRead, memWrite, irWrite;
        logic [1:0] regDst, memtoReg;
        logic       regWrite, aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
        logic       instrDone, illegalOp, busErr;
    } ctl_t;

    typedef struct packed {
        ctl_t          c;
        logic [CW-1:0] cnt;
        logic [15:0]   id;
    } sb_t;

    typedef enum int {
        X_IDLE, X_FETCH, X_FETCH_TO, X_DECODE, X_DECODE_ILL, X_REXEC, X_RWB, X_IEXEC, X_IWB,
        X_MADDR, X_MREAD, X_MREAD_TO, X_MWB, X_MWRITE, X_BRANCH, X_JUMP, X_JAL
    } xst_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CW)) dpBus ();

    multicycle_control #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (dpBus)
    );

    sb_t           sb[$];
    logic [CW-1:0] expCnt = '0;
    logic [15:0]   nextId = '0;
    int            nChecks = 0;
    int            nPass = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic ctl_t expWord(input xst_t s, input logic a, input logic [2:0] iop);
        ctl_t w = '0;
        case (s)
            X_FETCH:      begin w.memRead = 1; w.aluSrcB = 2'b01; w.irWrite = a; w.pcEn = a; end
            X_FETCH_TO:   begin w.memRead = 1; w.aluSrcB = 2'b01; w.busErr = 1; end
            X_DECODE:     w.aluSrcB = 2'b11;
            X_DECODE_ILL: begin w.aluSrcB = 2'b11; w.illegalOp = 1; end
            X_REXEC:      begin w.aluSrcA = 1; w.aluOp = 3'b010; end
            X_RWB:        begin w.regDst = 2'b01; w.regWrite = 1; w.instrDone = 1; end
            X_IEXEC:      begin w.aluSrcA = 1; w.aluSrcB = 2'b10; w.aluOp = iop; end
            X_IWB:        begin w.regWrite = 1; w.instrDone = 1; end
            X_MADDR:      begin w.aluSrcA = 1; w.aluSrcB = 2'b10; end
            X_MREAD:      begin w.memRead = 1; w.iorD = 1; end
            X_MREAD_TO:   begin w.memRead = 1; w.iorD = 1; w.busErr = 1; end
            X_MWB:        begin w.memtoReg = 2'b01; w.regWrite = 1; w.instrDone = 1; end
            X_MWRITE:     begin w.memWrite = 1; w.iorD = 1; w.instrDone = a; end
            X_BRANCH:     begin w.aluSrcA = 1; w.aluOp = 3'b001; w.pcSource = 2'b01; w.pcEn = a; w.instrDone = 1; end
            X_JUMP:       begin w.pcEn = 1; w.pcSource = 2'b10; w.instrDone = 1; end
            X_JAL:        begin w.pcEn = 1; w.pcSource = 2'b10; w.regWrite = 1; w.regDst = 2'b10;
                                w.memtoReg = 2'b10; w.instrDone = 1; end
            default:      w = '0;
        endcase
        return w;
    endfunction

    // One clock cycle: drive inputs just after the edge and queue what the outputs must be.
    task automatic cyc(input xst_t s, input logic [5:0] op, input logic z, input logic mr,
                       input logic rst, input logic [2:0] iop = 3'b000);
        sb_t e;
        @(posedge clk);
        #1;
        rst_n           = rst;
        dpBus.opCode    = op;
        dpBus.zero      = z;
        dpBus.memReady  = mr;
        e.c   = rst ? expWord(s, (s == X_BRANCH) ? z : mr, iop) : '0;
        e.cnt = rst ? expCnt : '0;
        e.id  = nextId;
        nextId++;
        sb.push_back(e);
        if (!rst) expCnt = '0;
        else if (e.c.instrDone) expCnt = expCnt + 1'b1;
    endtask

    task automatic fetchDecode(input logic [5:0] op, input xst_t dec);
        cyc(X_FETCH, op, 1'b0, 1'b1, 1'b1);
        cyc(dec, op, 1'b0, 1'b1, 1'b1);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t  e;
            ctl_t o;
            e = sb.pop_front();
            o = {dpBus.pcEn, dpBus.iorD, dpBus.memRead, dpBus.memWrite, dpBus.irWrite,
                 dpBus.regDst, dpBus.memtoReg, dpBus.regWrite, dpBus.aluSrcA, dpBus.aluSrcB,
                 dpBus.aluOp, dpBus.pcSource, dpBus.instrDone, dpBus.illegalOp, dpBus.busErr};
            checkVal($sformatf("c%0d.ctl", e.id), 32'(o), 32'(e.c));
            checkVal($sformatf("c%0d.cnt", e.id), 32'(dpBus.instrCount), 32'(e.cnt));
        end
    end

    logic [5:0] iOps[5]  = '{6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110};
    logic [2:0] iAlu[5]  = '{3'b000, 3'b110, 3'b011, 3'b100, 3'b101};

    initial begin
        dpBus.opCode   = 6'd0;
        dpBus.zero     = 1'b0;
        dpBus.memReady = 1'b0;
        repeat (2) @(posedge clk);
        // Reset cycle, then IDLE
        cyc(X_IDLE, 6'd0, 1'b0, 1'b1, 1'b0);
        cyc(X_IDLE, 6'd0, 1'b0, 1'b1, 1'b1);
        // ADD
        fetchDecode(6'b000000, X_DECODE);
        cyc(X_REXEC, 6'b000000, 1'b0, 1'b1, 1'b1);
        cyc(X_RWB, 6'b000000, 1'b0, 1'b1, 1'b1);
        // LW with three wait cycles; memReady arrives on the would-be expiry cycle
        fetchDecode(6'b100011, X_DECODE);
        cyc(X_MADDR, 6'b100011, 1'b0, 1'b1, 1'b1);
        repeat (3) cyc(X_MREAD, 6'b100011, 1'b0, 1'b0, 1'b1);
        cyc(X_MREAD, 6'b100011, 1'b0, 1'b1, 1'b1);
        cyc(X_MWB, 6'b100011, 1'b0, 1'b1, 1'b1);
        // BEQ taken, then not taken
        fetchDecode(6'b000100, X_DECODE);
        cyc(X_BRANCH, 6'b000100, 1'b1, 1'b1, 1'b1);
        fetchDecode(6'b000100, X_DECODE);
        cyc(X_BRANCH, 6'b000100, 1'b0, 1'b1, 1'b1);
        // SW
        fetchDecode(6'b101011, X_DECODE);
        cyc(X_MADDR, 6'b101011, 1'b0, 1'b1, 1'b1);
        cyc(X_MWRITE, 6'b101011, 1'b0, 1'b1, 1'b1);
        // I-type ALU ops
        for (int i = 0; i < 5; i++) begin
            fetchDecode(iOps[i], X_DECODE);
            cyc(X_IEXEC, iOps[i], 1'b0, 1'b1, 1'b1, iAlu[i]);
            cyc(X_IWB, iOps[i], 1'b0, 1'b1, 1'b1);
        end
        // J
        fetchDecode(6'b000010, X_DECODE);
        cyc(X_JUMP, 6'b000010, 1'b0, 1'b1, 1'b1);
        // Illegal opcode, then JAL (illegal unless enabled)
        fetchDecode(6'b111111, X_DECODE_ILL);
`ifdef MC_CTRL_JAL_EN
        fetchDecode(6'b000011, X_DECODE);
        cyc(X_JAL, 6'b000011, 1'b0, 1'b1, 1'b1);
`else
        fetchDecode(6'b000011, X_DECODE_ILL);
`endif
        // FETCH watchdog: no memReady for TO cycles
        repeat (TO - 1) cyc(X_FETCH, 6'd0, 1'b0, 1'b0, 1'b1);
        cyc(X_FETCH_TO, 6'd0, 1'b0, 1'b0, 1'b1);
        cyc(X_IDLE, 6'd0, 1'b0, 1'b0, 1'b1);
        fetchDecode(6'b000000, X_DECODE);
        cyc(X_REXEC, 6'b000000, 1'b0, 1'b1, 1'b1);
        cyc(X_RWB, 6'b000000, 1'b0, 1'b1, 1'b1);
        // MEM_READ watchdog
        fetchDecode(6'b100011, X_DECODE);
        cyc(X_MADDR, 6'b100011, 1'b0, 1'b1, 1'b1);
        repeat (TO - 1) cyc(X_MREAD, 6'b100011, 1'b0, 1'b0, 1'b1);
        cyc(X_MREAD_TO, 6'b100011, 1'b0, 1'b0, 1'b1);
        cyc(X_IDLE, 6'd0, 1'b0, 1'b0, 1'b1);
        // Enough jumps to wrap the 4-bit retire counter
        for (int i = 0; i < 6; i++) begin
            fetchDecode(6'b000010, X_DECODE);
            cyc(X_JUMP, 6'b000010, 1'b0, 1'b1, 1'b1);
        end
        // Reset in the middle of a SW wait
        fetchDecode(6'b101011, X_DECODE);
        cyc(X_MADDR, 6'b101011, 1'b0, 1'b1, 1'b1);
        cyc(X_MWRITE, 6'b101011, 1'b0, 1'b0, 1'b1);
        cyc(X_MWRITE, 6'b101011, 1'b0, 1'b0, 1'b0);
        cyc(X_IDLE, 6'd0, 1'b0, 1'b0, 1'b1);
        cyc(X_FETCH, 6'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        checkVal("sbDrained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
